// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_pkg;

    // Default instruction memory depth in words.
    localparam int IMEM_WORDS = 32;

    // Word index to byte address shift (4-byte instructions).
    localparam int ADDR_SHIFT = 2;

    // Loader FSM states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_CHK   = 3'd3,
        S_DONE  = 3'd4,
        S_FAIL  = 3'd5
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a big-endian byte stream into 32-bit words and keeps a running
// 8-bit additive checksum of every byte shifted in.
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        cnt_clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic [2:0]  byte_cnt,
    output logic [7:0]  sum
);

    // Shift accepted bytes in from the bottom so the first byte ends up in [31:24].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word     <= '0;
            byte_cnt <= '0;
            sum      <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_cnt <= '0;
            sum      <= '0;
        end else if (shift_en) begin
            word     <= {word[23:0], byte_data};
            sum      <= sum + byte_data;
            byte_cnt <= byte_cnt + 3'd1;
        end else if (cnt_clr) begin
            byte_cnt <= '0;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: receives a byte stream, writes
// packed words to addresses 0..N-1, verifies a trailing checksum and
// releases the CPU reset only after a clean load.
module imem_loader
    import imem_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LENGTH = IMEM_WORDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       load_len,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             cpu_rst_n
);

    localparam logic [6:0] LEN_MAX = 7'(LENGTH);

    state_t      state_q;
    state_t      state_d;
    logic [5:0]  word_idx;
    logic [5:0]  n_words;
    logic        done_q;
    logic        err_q;

    logic        pk_clear;
    logic        pk_cnt_clr;
    logic        pk_shift;
    logic [31:0] pk_word;
    logic [2:0]  pk_cnt;
    logic [7:0]  pk_sum;

    logic        start_idle;
    logic        len_ok;
    logic        last_word;
    logic        sum_match;

    assign start_idle = (state_q == S_IDLE) && start;
    assign len_ok     = (load_len != 6'd0) && ({1'b0, load_len} <= LEN_MAX);
    assign last_word  = (word_idx == (n_words - 6'd1));
    assign sum_match  = (byte_data == pk_sum);

    byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (pk_clear),
        .cnt_clr   (pk_cnt_clr),
        .shift_en  (pk_shift),
        .byte_data (byte_data),
        .word      (pk_word),
        .byte_cnt  (pk_cnt),
        .sum       (pk_sum)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        pk_clear   = 1'b0;
        pk_cnt_clr = 1'b0;
        pk_shift   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && len_ok) begin
                    pk_clear = 1'b1;
                    state_d  = S_RECV;
                end
            end
            S_RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                pk_shift   = byte_valid;
                if (byte_valid && (pk_cnt == 3'd3)) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                busy       = 1'b1;
                mem_we     = 1'b1;
                pk_cnt_clr = 1'b1;
                state_d    = last_word ? S_CHK : S_RECV;
            end
            S_CHK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) begin
                    state_d = sum_match ? S_DONE : S_FAIL;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Word counter and latched load length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx <= '0;
            n_words  <= '0;
        end else if (start_idle && len_ok) begin
            word_idx <= '0;
            n_words  <= load_len;
        end else if (state_q == S_WRITE) begin
            word_idx <= word_idx + 6'd1;
        end
    end

    // Sticky completion flags, cleared by any start accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (start_idle) begin
            done_q <= 1'b0;
            err_q  <= !len_ok;
        end else if ((state_q == S_CHK) && byte_valid) begin
            done_q <= sum_match;
            err_q  <= !sum_match;
        end
    end

    // A reload start drops done and the CPU reset in the cycle it is seen;
    // address and data are driven only while the write strobe is up.
    assign done      = done_q && !start_idle;
    assign cpu_rst_n = done_q && !start_idle;
    assign err       = err_q;
    assign mem_addr  = mem_we ? (WIDTH'(word_idx) << ADDR_SHIFT) : '0;
    assign mem_wdata = mem_we ? WIDTH'(pk_word) : '0;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader with a byte-list reference model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  load_len = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_rst_n;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_xfer = -10;
    int bytes_since = 0;
    bit busy_seen = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  img[$];

    imem_loader #(.WIDTH(32), .LENGTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .load_len   (load_len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_rst_n  (cpu_rst_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Passive monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_seen = 1;
            if (mem_we) begin
                chk("we_lat", cyc - last_xfer, 1);
                chk("we_bytes", bytes_since, 4);
                wa_q.push_back(mem_addr);
                wd_q.push_back(mem_wdata);
                bytes_since = 0;
            end
            if (byte_valid && byte_ready) begin
                last_xfer = cyc;
                bytes_since++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        bytes_since = 0;
        busy_seen = 0;
    endtask

    task automatic fill(input int n);
        img.delete();
        for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
    endtask

    function automatic logic [7:0] model_sum();
        int s = 0;
        foreach (img[i]) s += int'(img[i]);
        return 8'(s % 256);
    endfunction

    function automatic logic [31:0] model_word(input int k);
        return {img[4*k], img[4*k+1], img[4*k+2], img[4*k+3]};
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && t < 200) begin
            tick();
            t++;
        end
        if (!byte_ready) begin
            chk("byte_tmo", byte_ready, 1);
        end else begin
            tick();
            if (gaps && ($urandom % 3 == 0)) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                repeat (1 + $urandom % 3) tick();
            end
        end
    endtask

    task automatic start_load(input int n);
        clear_mon();
        start    = 1'b1;
        load_len = 6'(n);
        #1;
        chk("start_cpu", cpu_rst_n, 0);
        chk("start_done", done, 0);
        tick();
        start = 1'b0;
    endtask

    task automatic do_load(input int n, input logic [7:0] c, input bit gaps, input bit inj);
        int t = 0;
        bit ok;
        start_load(n);
        chk("busy_go", busy, 1);
        for (int i = 0; i < 4 * n; i++) begin
            if (inj && i == 2 * n) begin
                byte_valid = 1'b0;
                start      = 1'b1;
                load_len   = 6'd1;
                tick();
                start = 1'b0;
                chk("busy_hold", busy, 1);
            end
            send_byte(img[i], gaps);
        end
        send_byte(c, gaps);
        byte_valid = 1'b0;
        while (busy && t < 50) begin
            tick();
            t++;
        end
        chk("busy_end", busy, 0);
        tick();
        ok = (c == model_sum());
        chk("n_we", wa_q.size(), n);
        for (int k = 0; k < n && k < wa_q.size(); k++) begin
            chk("w_addr", wa_q[k], 32'(k * 4));
            chk("w_data", wd_q[k], model_word(k));
        end
        chk("done", done, ok);
        chk("err", err, !ok);
        chk("cpu_rst_n", cpu_rst_n, ok);
    endtask

    task automatic bad_len(input int l);
        clear_mon();
        start    = 1'b1;
        load_len = 6'(l);
        tick();
        start = 1'b0;
        chk("bad_err", err, 1);
        chk("bad_busy", busy, 0);
        chk("bad_done", done, 0);
        repeat (5) tick();
        chk("bad_busy_seen", busy_seen, 0);
        chk("bad_we", wa_q.size(), 0);
        chk("bad_cpu", cpu_rst_n, 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", byte_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cpu", cpu_rst_n, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [7:0] c;
        int n;
        repeat (3) tick();
        chk_reset_vals();
        rst_n = 1'b1;
        tick();

        // Nominal image.
        img = '{8'h3c, 8'h01, 8'h00, 8'h00, 8'h34, 8'h24, 8'h00, 8'h50};
        do_load(2, 8'he5, 0, 0);
        if (wd_q.size() == 2) begin
            chk("t1_w0", wd_q[0], 32'h3c010000);
            chk("t1_w1", wd_q[1], 32'h34240050);
        end else begin
            chk("t1_cnt", wd_q.size(), 2);
        end

        // Checksum mismatch, also a reload after done.
        do_load(2, 8'h00, 0, 0);

        // Illegal lengths.
        bad_len(0);
        bad_len(33);

        // Random images with stalls and random checksum outcome.
        for (int it = 0; it < 8; it++) begin
            n = 1 + int'($urandom % 8);
            fill(n);
            c = model_sum();
            if ($urandom % 2 == 1) c = c ^ 8'(1 + $urandom % 255);
            do_load(n, c, 1, 0);
        end

        // Full depth with a start pulse injected while busy.
        fill(32);
        do_load(32, model_sum(), 1, 1);
        if (wa_q.size() == 32) chk("t5_last", wa_q[31], 32'h7c);

        // Reset in the middle of the second word.
        fill(2);
        start_load(2);
        for (int i = 0; i < 6; i++) send_byte(img[i], 0);
        byte_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        chk("t6_we_cnt", wa_q.size(), 1);
        tick();
        tick();
        chk_reset_vals();
        rst_n = 1'b1;
        tick();
        chk("t6_idle_busy", busy, 0);
        fill(1);
        do_load(1, model_sum(), 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
